// File: rtl/axis_frame_framer.sv
// Pixel-stream framer: tags each accepted pixel with start-of-frame (tuser) and
// end-of-line (tlast) from position counters, and buffers it in a two-entry skid buffer.
module axis_frame_framer #(
    parameter int AXIS_DATA_WIDTH = 24,
    parameter int IMG_WIDTH       = 960,
    parameter int IMG_HEIGHT      = 540
) (
    input  logic                         aclk,
    input  logic                         arstn,
    input  logic                         soft_clr,
    input  logic                         s_pix_valid,
    output logic                         s_pix_ready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_pix_data,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic                         m_axis_tid,
    output logic                         m_axis_tdest,
    output logic                         frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // eof marks the pixel whose output handshake completes a frame
    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic                       last;
        logic                       user;
        logic                       eof;
    } entry_t;

    entry_t           out_reg, out_next;
    entry_t           skid_reg, skid_next;
    entry_t           in_entry;
    logic             out_valid_reg, out_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic             ready_reg, ready_next;
    logic             frame_done_reg, frame_done_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic             in_fire;
    logic             out_fire;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            col_reg        <= '0;
            row_reg        <= '0;
        end else begin
            out_reg        <= out_next;
            skid_reg       <= skid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= ready_next;
            frame_done_reg <= frame_done_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
        end
    end

    always_comb begin
        in_fire  = s_pix_valid && ready_reg;
        out_fire = out_valid_reg && m_axis_tready;

        in_entry.data = s_pix_data;
        in_entry.last = (col_reg == COL_LAST);
        in_entry.user = (col_reg == '0) && (row_reg == '0);
        in_entry.eof  = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

        out_next        = out_reg;
        skid_next       = skid_reg;
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        frame_done_next = out_fire && out_reg.eof;

        if (out_fire) begin
            if (skid_valid_reg) begin
                out_next        = skid_reg;
                skid_valid_next = 1'b0;
            end else begin
                out_valid_next  = 1'b0;
            end
        end

        // ready_reg high guarantees the skid entry is empty here
        if (in_fire) begin
            if (!out_valid_reg || (out_fire && !skid_valid_reg)) begin
                out_next       = in_entry;
                out_valid_next = 1'b1;
            end else begin
                skid_next       = in_entry;
                skid_valid_next = 1'b1;
            end
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end

        ready_next = !skid_valid_next;

        if (soft_clr) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
            col_next        = '0;
            row_next        = '0;
            ready_next      = 1'b0;
            frame_done_next = 1'b0;
        end
    end

    assign s_pix_ready   = ready_reg;
    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tdata  = out_reg.data;
    assign m_axis_tlast  = out_reg.last;
    assign m_axis_tuser  = out_reg.user;
    assign m_axis_tstrb  = '1;
    assign m_axis_tkeep  = '1;
    assign m_axis_tid    = 1'b0;
    assign m_axis_tdest  = 1'b0;
    assign frame_done    = frame_done_reg;

endmodule

// File: doc/axis_frame_framer.md
# axis_frame_framer

Upstream framing stage for the super-resolution pixel path. It accepts an unframed 24-bit RGB pixel stream over a plain valid/ready handshake and emits an AXI4-Stream master with framing markers:

- `tuser` marks start of frame.
- `tlast` marks end of line.

It derives the markers from programmed image dimensions and isolates both handshakes with a two-entry skid buffer. It feeds the AXI-stream slave port of the upscaler core.

## Interface
- `AXIS_DATA_WIDTH`, 24, pixel/tdata width; must be a multiple of 8. Strobe width is `AXIS_DATA_WIDTH/8`.
- `IMG_WIDTH`, 960, pixels per line (≥2).
- `IMG_HEIGHT`, 540, lines per frame (≥1).

Ports (clock and reset first):
- `aclk`  in  1  single clock; everything is synchronous to its rising edge.
- `arstn`  in  1  reset, asynchronous assert, active-low.
- `soft_clr`  in  1  synchronous flush. Drops buffered pixels and restarts framing at pixel (0,0).
- `s_pix_valid`  in  1  input pixel valid.
- `s_pix_ready`  out  1  input pixel ready; registered.
- `s_pix_data`  in  `AXIS_DATA_WIDTH`  RGB pixel.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  `AXIS_DATA_WIDTH`  pixel.
- `m_axis_tstrb`, `m_axis_tkeep`  out  `AXIS_DATA_WIDTH/8`  constant all-ones.
- `m_axis_tlast`  out  1  last pixel of a line.
- `m_axis_tuser`  out  1  first pixel of a frame.
- `m_axis_tid`, `m_axis_tdest`  out  1  constant 0.
- `frame_done`  out  1  one-cycle pulse on the output handshake of the last pixel of a frame.

## Operation
- **Input acceptance:** a pixel is accepted when `s_pix_valid && s_pix_ready`. On acceptance, the position counters tag the pixel:
  - `col` is `$clog2(IMG_WIDTH)` bits wide; `row` is `$clog2(IMG_HEIGHT)` bits wide.
  - `tuser = (col==0 && row==0)`.
  - `tlast = (col==IMG_WIDTH-1)`.
- **Counter update on acceptance:**
  - If `col==IMG_WIDTH-1`, `col` wraps to 0 and `row` advances.
  - If in addition `row==IMG_HEIGHT-1`, `row` also wraps to 0.
  - Otherwise `col` increments by 1.
  - Counters never reach values outside their ranges.
- **Storage:** two entries, `out_reg` (drives the `m_axis_*` outputs) and `skid_reg`. Each entry holds `{data, tlast, tuser}` plus a valid bit.
  - Input accepted while `out_reg` is empty, or while `out_reg` is being consumed (`m_axis_tvalid && m_axis_tready`) with `skid_reg` empty: the pixel loads into `out_reg`.
  - Input accepted while `out_reg` is valid and `m_axis_tready` is low: the pixel loads into `skid_reg`.
  - Output consumed while `skid_reg` is valid: `skid_reg` moves to `out_reg`, and `skid_reg` empties.
  - `s_pix_ready` is registered as `!skid_valid_next`. Ready therefore drops the cycle after the skid fills and rises the cycle after it drains. No pixel is ever dropped or duplicated.
- **`frame_done`:** registered; high for the cycle after an output handshake with `tlast && last-row` tag. A per-entry "end of frame" bit is carried with each entry for this purpose.
- **`soft_clr` (highest priority):**
  - Both entries are invalidated and `col`/`row` are cleared.
  - `s_pix_ready` is forced low for that cycle's registered value.
  - `frame_done` is not asserted.
  - A handshake on either side in the same cycle is discarded.
- **`arstn` low (asynchronous):**
  - All state returns to reset values immediately, mid-frame included.
  - After release, the next accepted pixel carries `tuser=1`.

## Timing
- **Reset values:**
  - `s_pix_ready=0`; it becomes 1 on the first `aclk` edge after `arstn` deasserts.
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `tlast=0`, `tuser=0`, `frame_done=0`.
  - Constant outputs (`tstrb`, `tkeep`, `tid`, `tdest`) hold their values in and out of reset.
- **Latency:** an input handshake at edge N gives `m_axis_tvalid=1` with that pixel after edge N.
- **Throughput:** 1 pixel/cycle sustained while `m_axis_tready=1`.
- **Output stability:** `m_axis_tvalid` never deasserts, and the `m_axis_*` payload never changes, while `m_axis_tvalid && !m_axis_tready`.
- **Simultaneous input and output handshake with `skid_reg` empty:** `out_reg` is replaced by the new pixel, and occupancy is unchanged.
- **`frame_done`:** asserted exactly 1 cycle after the final-pixel output handshake.

## Test plan
Tests use `IMG_WIDTH=4`, `IMG_HEIGHT=2`.
1. Continuous input, `m_axis_tready=1`, pixels 0..7 → output 0..7 one cycle later; `tuser` only on pixel 0; `tlast` on pixels 3 and 7; `frame_done` pulse one cycle after pixel 7's handshake.
2. Input every cycle, `m_axis_tready` toggles 1,0,0,1,… → output sequence 0..15 in order with no gaps or duplicates; `s_pix_ready` falls one cycle after the skid fills; payload stable during stalls.
3. Two back-to-back frames (16 pixels) → `tuser` on pixels 0 and 8; `tlast` on 3, 7, 11, 15; two `frame_done` pulses.
4. `soft_clr` after 5 pixels accepted with output stalled → `m_axis_tvalid=0` next cycle; next accepted pixel has `tuser=1`, col 0; no `frame_done` pulse.
5. `arstn` asserted mid-line (pixel 2 held in `out_reg`) → all outputs 0 immediately; after release, `s_pix_ready` rises within 1 cycle and the next pixel has `tuser=1`.
6. Random valid/ready at 50% each, 1000 pixels → scoreboard matches data order; `tlast` count = 250; `tuser` count = 125; `frame_done` count = 125.
